// File: rtl/digit_serial_addsub.sv
// rtl/digit_serial_addsub.sv - digit-serial adder/subtractor, one DIGIT-bit slice per cycle
//
// Adds or subtracts two WIDTH-bit operands over WIDTH/DIGIT cycles, least
// significant digit first, keeping the inter-digit carry in a register.
// Subtraction is done as A + ~B + ~c_in, so C_out = 1 means "no borrow".
//
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-high reset
//   start_i  begin an operation (accepted in IDLE or DONE, ignored in RUN)
//   sub_i    0 = add, 1 = subtract (sampled with start_i)
//   a_i      operand A (sampled with start_i)
//   b_i      operand B (sampled with start_i)
//   c_in     carry-in (add) / borrow-in (subtract), sampled with start_i
//   busy_o   high while digits are being processed
//   done_o   one-cycle pulse, results valid
//   S_o      sum / difference, held until the next completion
//   C_out    carry out of the MSB, held until the next completion
//   ovf_o    signed overflow, held until the next completion

module digit_serial_addsub #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             sub_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             c_in,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] S_o,
  output logic             C_out,
  output logic             ovf_o
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] s_sr;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic [DIGIT:0]   dig;
  logic [DIGIT-1:0] dsum;
  logic             dcarry;
  logic             msb_cin;
  logic [WIDTH-1:0] s_next;

  // One DIGIT-bit ripple slice on the low digit of the operand registers.
  assign dig    = {1'b0, a_sr[DIGIT-1:0]} + {1'b0, b_sr[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};
  assign dsum   = dig[DIGIT-1:0];
  assign dcarry = dig[DIGIT];

  // Carry into the top bit of this digit, recovered from sum = a ^ b ^ cin.
  // On the last digit this is the carry into bit WIDTH-1.
  assign msb_cin = dsum[DIGIT-1] ^ a_sr[DIGIT-1] ^ b_sr[DIGIT-1];

  // New digit enters at the top; after N shifts digit 0 lands at bit 0.
  // Written as shifts so DIGIT == WIDTH needs no special case.
  assign s_next = (s_sr >> DIGIT) | (WIDTH'(dsum) << (WIDTH - DIGIT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      s_sr   <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
      S_o    <= '0;
      C_out  <= 1'b0;
      ovf_o  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done_o <= 1'b0;
          if (start_i) begin
            a_sr   <= a_i;
            b_sr   <= sub_i ? ~b_i : b_i;
            carry  <= c_in ^ sub_i;
            cnt    <= '0;
            busy_o <= 1'b1;
            state  <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          a_sr  <= a_sr >> DIGIT;
          b_sr  <= b_sr >> DIGIT;
          s_sr  <= s_next;
          carry <= dcarry;
          cnt   <= cnt + 1'b1;
          if (cnt == CW'(N - 1)) begin
            state  <= DONE;
            busy_o <= 1'b0;
            done_o <= 1'b1;
            S_o    <= s_next;
            C_out  <= dcarry;
            ovf_o  <= msb_cin ^ dcarry;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_digit_serial_addsub.sv
// tb/tb_digit_serial_addsub.sv - self-checking bench for digit_serial_addsub across several WIDTH/DIGIT shapes

module tb_digit_serial_addsub;

  localparam int NI  = 5;
  localparam int WS [NI] = '{16, 16, 16, 8, 12};
  localparam int DS [NI] = '{4, 1, 16, 2, 3};
  localparam int OPS = 1000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_v   [NI];
  logic        start_v [NI];
  logic        sub_v   [NI];
  logic        cin_v   [NI];
  logic [15:0] a_v     [NI];
  logic [15:0] b_v     [NI];

  wire         busy_w [NI];
  wire         done_w [NI];
  wire         c_w    [NI];
  wire         v_w    [NI];
  wire  [15:0] s_w    [NI];

  generate
    for (genvar g = 0; g < NI; g++) begin : g_dut
      localparam int W = WS[g];
      localparam int D = DS[g];
      logic [W-1:0] s_loc;
      digit_serial_addsub #(.WIDTH(W), .DIGIT(D)) u_dut (
        .clk     (clk),
        .rst     (rst_v[g]),
        .start_i (start_v[g]),
        .sub_i   (sub_v[g]),
        .a_i     (a_v[g][W-1:0]),
        .b_i     (b_v[g][W-1:0]),
        .c_in    (cin_v[g]),
        .busy_o  (busy_w[g]),
        .done_o  (done_w[g]),
        .S_o     (s_loc),
        .C_out   (c_w[g]),
        .ovf_o   (v_w[g])
      );
      assign s_w[g] = 16'(s_loc);
    end
  endgenerate

  int errors = 0;
  int checks = 0;
  bit sim_end = 0;

  // Reference model state: cycles remaining, expected outputs, pending result.
  int          left  [NI];
  int          ndone [NI];
  bit          eb [NI], ed [NI], ec [NI], ev [NI];
  logic [15:0] es [NI];
  logic [15:0] ps [NI];
  logic        pc [NI], pv [NI];

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors < 50) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Plain integer arithmetic: a +/- b +/- cin at width w.
  function automatic void ref_op(input int w, input logic sb, input logic [15:0] a,
                                 input logic [15:0] b, input logic ci,
                                 output logic [15:0] s, output logic c, output logic v);
    longint mask, ua, ub, sa, sbv, r, sr, smax, smin, lc;
    mask = (longint'(1) << w) - 1;
    smax = (longint'(1) << (w - 1)) - 1;
    smin = -smax - 1;
    ua = longint'(a) & mask;
    ub = longint'(b) & mask;
    lc = longint'(ci);
    sa  = (ua > smax) ? ua - (mask + 1) : ua;
    sbv = (ub > smax) ? ub - (mask + 1) : ub;
    if (!sb) begin
      r  = ua + ub + lc;
      c  = (r > mask);
      sr = sa + sbv + lc;
    end else begin
      r  = ua - ub - lc;
      c  = (ua >= ub + lc);
      sr = sa - sbv - lc;
    end
    s = 16'(r & mask);
    v = (sr > smax) || (sr < smin);
  endfunction

  task automatic monitor();
    while (!sim_end) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NI; i++) begin
        if (rst_v[i]) begin
          left[i] = 0; eb[i] = 0; ed[i] = 0; es[i] = '0; ec[i] = 0; ev[i] = 0;
        end else if (left[i] > 0) begin
          left[i]--;
          ed[i] = 0;
          if (left[i] == 0) begin
            eb[i] = 0; ed[i] = 1;
            es[i] = ps[i]; ec[i] = pc[i]; ev[i] = pv[i];
            ndone[i]++;
          end
        end else begin
          ed[i] = 0;
          if (start_v[i]) begin
            left[i] = WS[i] / DS[i];
            eb[i] = 1;
            ref_op(WS[i], sub_v[i], a_v[i], b_v[i], cin_v[i], ps[i], pc[i], pv[i]);
          end
        end
        chk($sformatf("outs{busy,done,c,ovf,s} inst%0d", i),
            longint'({busy_w[i], done_w[i], c_w[i], v_w[i], s_w[i]}),
            longint'({eb[i], ed[i], ec[i], ev[i], es[i]}));
      end
    end
  endtask

  task automatic drive0(input logic sb, input logic [15:0] a, input logic [15:0] b, input logic ci);
    sub_v[0] = sb; a_v[0] = a; b_v[0] = b; cin_v[0] = ci;
  endtask

  // Called at a negedge; counts negedges until done_o is seen (bounded).
  task automatic wait_done0(output int m, output int bn);
    m = 0; bn = 0;
    while (!done_w[0] && m < 40) begin
      bn += int'(busy_w[0]);
      @(negedge clk);
      m++;
    end
  endtask

  task automatic dir_op(input string nm, input logic sb, input logic [15:0] a, input logic [15:0] b,
                        input logic ci, input logic [15:0] xs, input logic xc, input logic xv);
    int m, bn;
    logic [15:0] ms;
    logic mc, mv;
    ref_op(16, sb, a, b, ci, ms, mc, mv);
    chk({nm, " model S"}, ms, xs);
    chk({nm, " model C"}, mc, xc);
    chk({nm, " model ovf"}, mv, xv);
    @(negedge clk);
    drive0(sb, a, b, ci);
    start_v[0] = 1;
    @(negedge clk);
    start_v[0] = 0;
    drive0(1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom));
    wait_done0(m, bn);
    chk({nm, " latency"}, m, 4);
    chk({nm, " busy cycles"}, bn, 4);
    chk({nm, " S"}, s_w[0], xs);
    chk({nm, " C"}, c_w[0], xc);
    chk({nm, " ovf"}, v_w[0], xv);
  endtask

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 5))
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return 16'h8000;
      3: return 16'h7FFF;
      4: return 16'h0001;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic stimulus();
    int m, m2, bn, nd, cyc;
    bit all_done;
    repeat (2) @(negedge clk);
    chk("reset state", longint'({busy_w[0], done_w[0], c_w[0], v_w[0], s_w[0]}), 0);
    for (int i = 0; i < NI; i++) rst_v[i] = 0;

    dir_op("add ffff+1",   0, 16'hFFFF, 16'h0001, 0, 16'h0000, 1, 0);
    dir_op("add 7fff+1",   0, 16'h7FFF, 16'h0001, 0, 16'h8000, 0, 1);
    dir_op("sub 5-7",      1, 16'h0005, 16'h0007, 0, 16'hFFFE, 0, 0);
    dir_op("sub 8000-1",   1, 16'h8000, 16'h0001, 0, 16'h7FFF, 1, 1);
    dir_op("sub 5-3-1",    1, 16'h0005, 16'h0003, 1, 16'h0001, 1, 0);

    // start_i during RUN is ignored
    @(negedge clk); drive0(0, 16'h1234, 16'h1111, 0); start_v[0] = 1;
    @(negedge clk); start_v[0] = 0;
    @(negedge clk); drive0(1, 16'hAAAA, 16'h5555, 1); start_v[0] = 1;
    @(negedge clk); start_v[0] = 0;
    nd = 0;
    for (int k = 0; k < 12; k++) begin
      if (done_w[0]) begin
        nd++;
        chk("ignored start S", s_w[0], 16'h2345);
        chk("ignored start C", c_w[0], 0);
      end
      @(negedge clk);
    end
    chk("ignored start done count", nd, 1);

    // start_i held high: back-to-back results N+1 cycles apart
    @(negedge clk); drive0(0, 16'h8000, 16'h8000, 1); start_v[0] = 1;
    @(negedge clk); drive0(1, 16'h0000, 16'h0001, 0);
    wait_done0(m, bn);
    chk("b2b first latency", m, 4);
    chk("b2b first S", s_w[0], 16'h0001);
    chk("b2b first C", c_w[0], 1);
    chk("b2b first ovf", v_w[0], 1);
    @(negedge clk);
    wait_done0(m2, bn);
    start_v[0] = 0;
    chk("b2b gap", m2 + 1, 5);
    chk("b2b second S", s_w[0], 16'hFFFF);
    chk("b2b second C", c_w[0], 0);
    chk("b2b second ovf", v_w[0], 0);

    // reset during the second RUN cycle
    @(negedge clk); drive0(0, 16'h00FF, 16'h0F0F, 0); start_v[0] = 1;
    @(negedge clk); start_v[0] = 0;
    @(negedge clk); rst_v[0] = 1;
    #1;
    chk("mid-run reset outs", longint'({busy_w[0], done_w[0], c_w[0], v_w[0], s_w[0]}), 0);
    @(negedge clk); rst_v[0] = 0;
    nd = 0;
    repeat (10) begin @(negedge clk); nd += int'(done_w[0]); end
    chk("no done after reset", nd, 0);
    dir_op("fresh after reset", 0, 16'h00FF, 16'h0F0F, 0, 16'h100E, 0, 0);

    // randomized sweep on every instance, model checks every cycle
    cyc = 0;
    all_done = 0;
    while (!all_done && cyc < 40000) begin
      @(negedge clk);
      cyc++;
      all_done = 1;
      for (int i = 0; i < NI; i++) begin
        if (ndone[i] < OPS) all_done = 0;
        start_v[i] = (ndone[i] < OPS) && ($urandom_range(0, 1) == 0);
        sub_v[i]   = 1'($urandom);
        cin_v[i]   = 1'($urandom);
        a_v[i]     = pick();
        b_v[i]     = pick();
      end
    end
    chk("random sweep completed", all_done, 1);
    for (int i = 0; i < NI; i++) start_v[i] = 0;
    repeat (40) @(negedge clk);
    sim_end = 1;
  endtask

  initial begin
    for (int i = 0; i < NI; i++) begin
      rst_v[i] = 1; start_v[i] = 0; sub_v[i] = 0; cin_v[i] = 0;
      a_v[i] = '0; b_v[i] = '0;
      left[i] = 0; ndone[i] = 0;
      eb[i] = 0; ed[i] = 0; ec[i] = 0; ev[i] = 0; es[i] = '0;
      ps[i] = '0; pc[i] = 0; pv[i] = 0;
    end
    fork
      monitor();
      stimulus();
    join
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/digit_serial_addsub.md
# digit_serial_addsub

Parametrised, multi-cycle adder/subtractor that extends the single-bit full-adder cell into a WIDTH-bit datapath. Each cycle it processes one DIGIT-bit slice, least-significant first, and ripples the carry through a register between cycles. A start/busy/done handshake frames each operation. It serves the arithmetic datapath wherever area matters more than latency, and it doubles as the reference harness for exercising full-adder chains at arbitrary widths.

## Interface
- WIDTH, 16, operand and result width in bits; must be a multiple of DIGIT and at least 1.
- DIGIT, 4, bits processed per cycle; 1 gives bit-serial operation, WIDTH gives a single-cycle ripple.
- clk  input  1  rising-edge clock, the only clock.
- rst  input  1  asynchronous, active-high reset.
- start_i  input  1  request a new operation; sampled on the rising edge of clk.
- sub_i  input  1  0 = add, 1 = subtract; sampled together with start_i.
- a_i  input  WIDTH  operand A; sampled with start_i.
- b_i  input  WIDTH  operand B; sampled with start_i.
- c_in  input  1  carry-in when adding, borrow-in when subtracting; sampled with start_i.
- busy_o  output  1  high while digits are being processed.
- done_o  output  1  one-cycle pulse indicating that the result outputs are valid.
- S_o  output  WIDTH  sum or difference.
- C_out  output  1  carry-out of the MSB. When subtracting, 1 means no borrow.
- ovf_o  output  1  two's-complement signed overflow.

## Operation
- N = WIDTH/DIGIT digits per operation.
- The state machine has three states: IDLE, RUN and DONE.
- IDLE/DONE -> RUN, when start_i=1:
  - latch a_i into the A shift register;
  - latch b_i into the B shift register when sub_i=0, or ~b_i when sub_i=1;
  - set the carry register to c_in when sub_i=0, or ~c_in when sub_i=1;
  - clear the digit counter.
- IDLE/DONE with start_i=0: DONE returns to IDLE; IDLE stays in IDLE.
- Each RUN cycle:
  - add the low DIGIT bits of A and B plus the carry register;
  - write the DIGIT-bit result into the top of the S shift register, shifting it right by DIGIT;
  - shift A and B right by DIGIT;
  - store the new carry in the carry register;
  - increment the counter.
- RUN -> DONE after the digit with counter value N-1. On that edge:
  - C_out takes the final carry;
  - ovf_o = (carry into the MSB) XOR (carry out of the MSB). Capture the carry into bit WIDTH-1 from inside the last digit.
- Subtraction computes A - B - c_in = A + ~B + ~c_in.
- S_o, C_out and ovf_o hold their values from the DONE edge until the next DONE edge. They are not cleared on start.
- start_i is ignored while in RUN. No queuing, no error flag.
- Accepting start_i in DONE allows back-to-back operations: throughput is one result per N+1 cycles.

## Timing
- Reset (asynchronous, takes effect immediately): state = IDLE; busy_o = 0, done_o = 0, S_o = 0, C_out = 0, ovf_o = 0; internal registers cleared.
- Reset asserted mid-RUN aborts the operation. No done_o pulse is produced, and the previous result is lost (all outputs are 0).
- Start accepted at edge k:
  - busy_o is high for edges k+1 .. k+N, i.e. N cycles;
  - done_o is high for exactly the one cycle after edge k+N;
  - results are valid in that same cycle.
- Latency from the start edge to done_o is N cycles. With DIGIT=WIDTH, done_o appears one cycle after start.
- busy_o and done_o are never high at the same time.
- Operand inputs may change freely after the start edge; only the latched copies are used.
- Combinational path per cycle is a DIGIT-bit ripple plus register setup.

## Test plan
- Add, WIDTH=16, DIGIT=4: A=0xFFFF, B=0x0001, c_in=0. Expect S_o=0x0000, C_out=1, ovf_o=0; done_o exactly 4 cycles after the start edge; busy_o high for 4 cycles.
- Add with signed overflow: A=0x7FFF, B=0x0001, c_in=0. Expect S_o=0x8000, C_out=0, ovf_o=1.
- Subtract cases:
  - A=0x0005, B=0x0007, c_in=0: expect S_o=0xFFFE, C_out=0, ovf_o=0.
  - A=0x8000, B=0x0001, c_in=0: expect S_o=0x7FFF, C_out=1, ovf_o=1.
  - A=0x0005, B=0x0003, c_in=1: expect S_o=0x0001, C_out=1.
- Handshake:
  - start_i pulsed again during RUN with different operands: the first result is unaffected and done_o pulses once.
  - start_i held high through DONE: a back-to-back result arrives N+1 cycles later.
- Reset asserted during the second RUN cycle: all outputs are 0 immediately and no done_o follows. A fresh start afterwards yields the correct result.
- Parameter sweep (WIDTH, DIGIT) in {(16,1), (16,16), (8,2), (12,3)}: 1000 random add/sub operations each, checked against a behavioural model of a ± b ± c_in, including C_out and ovf_o. Latency must equal WIDTH/DIGIT in every case.
